// File: rtl/ps2_pkg.sv
// Shared constants, FSM encodings and event record for the PS/2 scan-code sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] PS2_BRK      = 8'hF0;
  localparam logic [7:0] PS2_PAUSE    = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
  localparam logic [7:0] PS2_OVR0     = 8'h00;
  localparam logic [7:0] PS2_OVRF     = 8'hFF;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  // Pause is E1 followed by 7 bytes we swallow without inspection.
  localparam logic [2:0] PAUSE_LAST = 3'd6;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Bytes that cannot legally follow a prefix inside a sequence.
  function automatic logic ps2_bad_in_seq(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE) ||
           (b == PS2_OVR0) || (b == PS2_OVRF);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO; dout holds the last popped entry while empty.
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? last_q : mem[rd_ptr];

  // Storage array, no reset needed: only entries below cnt are ever shown.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer/occupancy bookkeeping and the held-output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// Set-2 multi-byte sequence parser: E0/F0/E1 handling, BAT status, timeout, event FIFO.
module ps2_scancode_ctrl
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       kbd_ready,
  output logic       seq_err,
  output logic       overflow,
  output logic [2:0] state
);

  localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  logic [2:0]    nxt_state;
  logic [2:0]    pcnt, nxt_pcnt;
  logic          nxt_kbd;
  logic          push, err;
  ps2_evt_t      push_evt, head;
  logic [TW-1:0] timer;
  logic          timeout;
  logic          fifo_empty, fifo_full, pop;

  assign timeout = (state != S_IDLE) && !rx_done && (timer == TW'(TO_CYC - 1));
  assign pop     = evt_valid & evt_ready;

  // Next-state decode; only rx_done cycles or a timeout change anything.
  always_comb begin
    nxt_state = state;
    nxt_pcnt  = pcnt;
    nxt_kbd   = kbd_ready;
    push      = 1'b0;
    err       = 1'b0;
    push_evt  = '{ext: 1'b0, brk: 1'b0, code: rx_data};
    if (rx_done) begin
      case (state)
        S_IDLE: begin
          if (rx_data == PS2_EXT)                               nxt_state = S_EXT;
          else if (rx_data == PS2_BRK)                          nxt_state = S_BRK;
          else if (rx_data == PS2_PAUSE) begin nxt_state = S_PAUSE; nxt_pcnt = '0; end
          else if (rx_data == PS2_BAT_OK)                       nxt_kbd = 1'b1;
          else if (rx_data == PS2_BAT_FAIL)                     nxt_kbd = 1'b0;
          else if (rx_data == PS2_OVR0 || rx_data == PS2_OVRF)  err = 1'b1;
          else                                                  push = 1'b1;
        end
        S_EXT, S_BRK, S_EXT_BRK: begin
          nxt_state = S_IDLE;
          if (state == S_EXT && rx_data == PS2_BRK) begin
            nxt_state = S_EXT_BRK;
          end else if (ps2_bad_in_seq(rx_data)) begin
            err = 1'b1;
          end else begin
            push         = 1'b1;
            push_evt.ext = (state != S_BRK);
            push_evt.brk = (state != S_EXT);
          end
        end
        S_PAUSE: begin
          if (pcnt == PAUSE_LAST) begin
            push      = 1'b1;
            push_evt  = '{ext: 1'b1, brk: 1'b0, code: PS2_PAUSE};
            nxt_state = S_IDLE;
          end else begin
            nxt_pcnt = pcnt + 3'd1;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end else if (timeout) begin
      err       = 1'b1;
      nxt_state = S_IDLE;
    end
  end

  // FSM, status flags and registered error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pcnt      <= '0;
      kbd_ready <= 1'b0;
      seq_err   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= nxt_state;
      pcnt      <= nxt_pcnt;
      kbd_ready <= nxt_kbd;
      seq_err   <= err;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Inter-byte timer: idle and every received byte restart it.
  always_ff @(posedge clk) begin
    if (reset || rx_done || state == S_IDLE || timeout) timer <= '0;
    else                                                 timer <= timer + TW'(1);
  end

  ps2_evt_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_evt),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Directed bench for ps2_scancode_ctrl; TO_CYC shrunk to 20 cycles for the timeout cases.
module tb_ps2_scancode_ctrl;

  localparam int TO_CYC = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_ext, evt_break, kbd_ready, seq_err, overflow;
  logic [7:0] evt_code;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_base;

  ps2_scancode_ctrl #(.CLK_HZ(10_000_000), .TIMEOUT_US(2), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .kbd_ready (kbd_ready),
    .seq_err   (seq_err),
    .overflow  (overflow),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Count cycles in which seq_err was high.
  always @(posedge clk) if (seq_err === 1'b1) err_seen <= err_seen + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; rx_done is sampled at the following posedge.
  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_evt(input string tag, input logic [7:0] code,
                            input logic ext, input logic brk);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_code"},  32'(evt_code),  32'(code));
    chk({tag, "_ext"},   32'(evt_ext),   32'(ext));
    chk({tag, "_brk"},   32'(evt_break), 32'(brk));
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Reset values
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_code",  32'(evt_code),  32'd0);
    chk("rst_ext",   32'(evt_ext),   32'd0);
    chk("rst_brk",   32'(evt_break), 32'd0);
    chk("rst_kbd",   32'(kbd_ready), 32'd0);
    chk("rst_err",   32'(seq_err),   32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    chk("rst_state", 32'(state),     32'd0);

    // Plain make code, visible the cycle after rx_done
    send(8'h1C);
    expect_evt("make", 8'h1C, 1'b0, 1'b0);
    chk("make_empty", 32'(evt_valid), 32'd0);
    chk("make_hold",  32'(evt_code),  32'h1C);

    send(8'hF0); send(8'h1C);
    expect_evt("brk", 8'h1C, 1'b0, 1'b1);
    send(8'hE0); send(8'h75);
    expect_evt("ext", 8'h75, 1'b1, 1'b0);
    send(8'hE0); send(8'hF0);
    chk("extbrk_state", 32'(state), 32'd3);
    send(8'h75);
    expect_evt("extbrk", 8'h75, 1'b1, 1'b1);

    // Pause: one event only, no error
    err_base = err_seen;
    send(8'hE1);
    chk("pause_state", 32'(state), 32'd4);
    send(8'h14); send(8'h77); send(8'hE1); send(8'hF0);
    send(8'h14); send(8'hF0);
    chk("pause_wait", 32'(evt_valid), 32'd0);
    send(8'h77);
    chk("pause_idle", 32'(state), 32'd0);
    expect_evt("pause", 8'hE1, 1'b1, 1'b0);
    chk("pause_one", 32'(evt_valid), 32'd0);
    chk("pause_noerr", 32'(err_seen - err_base), 32'd0);

    // BAT status
    send(8'hAA);
    chk("bat_ok",   32'(kbd_ready), 32'd1);
    chk("bat_noev", 32'(evt_valid), 32'd0);
    send(8'hFC);
    chk("bat_fail", 32'(kbd_ready), 32'd0);

    // Timeout after F0
    err_base = err_seen;
    send(8'hF0);
    repeat (TO_CYC - 1) @(negedge clk);
    chk("to_before", 32'(state), 32'd2);
    @(negedge clk);
    chk("to_state", 32'(state),   32'd0);
    chk("to_err",   32'(seq_err), 32'd1);
    @(negedge clk);
    chk("to_pulse", 32'(err_seen - err_base), 32'd1);
    send(8'h1C);
    expect_evt("to_next", 8'h1C, 1'b0, 1'b0);

    // Byte in the timeout cycle wins
    err_base = err_seen;
    send(8'hF0);
    repeat (TO_CYC - 1) @(negedge clk);
    send(8'h1C);
    @(negedge clk);
    chk("race_noerr", 32'(err_seen - err_base), 32'd0);
    expect_evt("race", 8'h1C, 1'b0, 1'b1);

    // Overflow: 5 makes into a 4-deep FIFO
    send(8'h11); send(8'h12); send(8'h13); send(8'h14);
    chk("full_noovf", 32'(overflow), 32'd0);
    send(8'h15);
    chk("ovf", 32'(overflow), 32'd1);
    expect_evt("drain0", 8'h11, 1'b0, 1'b0);
    expect_evt("drain1", 8'h12, 1'b0, 1'b0);
    expect_evt("drain2", 8'h13, 1'b0, 1'b0);
    expect_evt("drain3", 8'h14, 1'b0, 1'b0);
    chk("drain_empty", 32'(evt_valid), 32'd0);

    // Reset mid-sequence with FIFO contents
    send(8'h21); send(8'hE0);
    do_reset();
    chk("mrst_valid", 32'(evt_valid), 32'd0);
    chk("mrst_state", 32'(state),     32'd0);
    chk("mrst_ovf",   32'(overflow),  32'd0);
    send(8'h75);
    expect_evt("mrst_next", 8'h75, 1'b0, 1'b0);

    // Full FIFO with simultaneous pop and push
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    evt_ready = 1'b1;
    send(8'h35);
    evt_ready = 1'b0;
    chk("pp_noovf", 32'(overflow), 32'd0);
    expect_evt("pp0", 8'h32, 1'b0, 1'b0);
    expect_evt("pp1", 8'h33, 1'b0, 1'b0);
    expect_evt("pp2", 8'h34, 1'b0, 1'b0);
    expect_evt("pp3", 8'h35, 1'b0, 1'b0);

    // E0 E0 aborts; the aborting byte is not reparsed
    err_base = err_seen;
    send(8'hE0); send(8'hE0);
    chk("ee_state", 32'(state), 32'd0);
    @(negedge clk);
    chk("ee_err",   32'(err_seen - err_base), 32'd1);
    chk("ee_noev",  32'(evt_valid), 32'd0);
    send(8'h1C);
    expect_evt("ee_next", 8'h1C, 1'b0, 1'b0);

    // Overrun byte in idle
    err_base = err_seen;
    send(8'hFF);
    @(negedge clk);
    chk("ovr_err",  32'(err_seen - err_base), 32'd1);
    chk("ovr_noev", 32'(evt_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
